// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - request, memory-port and response signals of the memory sequencer
interface mem_sequencer_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_kind;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic [XLEN-1:0] mem_address;
    logic            mem_read;
    logic            mem_write;
    logic [NB-1:0]   mem_byte_enable;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_resp;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic [1:0]      rsp_err;
    logic [NB-1:0]   rmask;
    logic [NB-1:0]   wmask;

    modport slave (
        input  req_valid, req_kind, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
        output req_ready, mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
               rsp_valid, rsp_data, rsp_err, rmask, wmask
    );

    modport master (
        output req_valid, req_kind, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
        input  req_ready, mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
               rsp_valid, rsp_data, rsp_err, rmask, wmask
    );
endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - fetch/load/store sequencer with lane masks, extension, misalign and timeout
module mem_sequencer #(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_sequencer_if.slave  bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [OW-1:0]   off, off_q;
    logic [1:0]      dec_size, size_q;
    logic            dec_sign, sign_q, dec_ill, dec_mis;
    logic [1:0]      dec_err;
    logic [7:0]      be_base;
    logic [NB-1:0]   dec_be;
    logic            accept, timeout;
    logic [XLEN-1:0] rd_shift, rd_mask, rd_ext;
    logic            rd_msb;

    assign off           = bus.req_addr[OW-1:0];
    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign accept        = bus.req_valid & bus.req_ready;

    // dec_size is log2 of the access size in bytes
    always_comb begin
        dec_size = 2'd2;
        dec_sign = 1'b0;
        dec_ill  = 1'b0;
        case (bus.req_kind)
            2'b00: dec_size = 2'd2;
            2'b01: begin
                case (bus.req_funct3)
                    3'b000: begin dec_size = 2'd0; dec_sign = 1'b1; end
                    3'b001: begin dec_size = 2'd1; dec_sign = 1'b1; end
                    3'b010: begin dec_size = 2'd2; dec_sign = 1'b1; end
                    3'b011: begin dec_size = 2'd3; dec_ill = (XLEN == 32); end
                    3'b100: dec_size = 2'd0;
                    3'b101: dec_size = 2'd1;
                    3'b110: begin dec_size = 2'd2; dec_ill = (XLEN == 32); end
                    default: dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                case (bus.req_funct3)
                    3'b000: dec_size = 2'd0;
                    3'b001: dec_size = 2'd1;
                    3'b010: dec_size = 2'd2;
                    3'b011: begin dec_size = 2'd3; dec_ill = (XLEN == 32); end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase

        case (dec_size)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        dec_be  = NB'(be_base) << off;
        dec_mis = (off & OW'((1 << dec_size) - 1)) != '0;
        dec_err = dec_ill ? 2'b11 : (dec_mis ? 2'b01 : 2'b00);
    end

    assign timeout = (WAIT_MAX != 0) && (state == S_ACCESS) && !bus.mem_resp
                     && (wait_cnt == CW'(WAIT_MAX - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = (dec_err != 2'b00) ? S_RESP : S_ACCESS;
            S_ACCESS: if (bus.mem_resp || timeout) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // lane-select the returned word, then truncate and extend to the access size
    always_comb begin
        rd_shift = bus.mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    begin rd_mask = XLEN'(8'hFF);         rd_msb = rd_shift[7];      end
            2'd1:    begin rd_mask = XLEN'(16'hFFFF);      rd_msb = rd_shift[15];     end
            2'd2:    begin rd_mask = XLEN'(32'hFFFF_FFFF); rd_msb = rd_shift[31];     end
            default: begin rd_mask = '1;                   rd_msb = rd_shift[XLEN-1]; end
        endcase
        rd_ext = (rd_shift & rd_mask) | ((sign_q && rd_msb) ? ~rd_mask : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_address     <= '0;
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.mem_byte_enable <= '0;
            bus.mem_wdata       <= '0;
            bus.rsp_data        <= '0;
            bus.rsp_err         <= 2'b00;
            bus.rmask           <= '0;
            bus.wmask           <= '0;
            off_q               <= '0;
            size_q              <= 2'd0;
            sign_q              <= 1'b0;
            wait_cnt            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wait_cnt <= '0;
                        if (dec_err != 2'b00) begin
                            bus.rsp_err  <= dec_err;
                            bus.rsp_data <= '0;
                            bus.rmask    <= '0;
                            bus.wmask    <= '0;
                        end else begin
                            bus.mem_address     <= {bus.req_addr[XLEN-1:OW], {OW{1'b0}}};
                            bus.mem_read        <= (bus.req_kind != 2'b10);
                            bus.mem_write       <= (bus.req_kind == 2'b10);
                            bus.mem_byte_enable <= dec_be;
                            bus.mem_wdata       <= (bus.req_kind == 2'b10)
                                                   ? (bus.req_wdata << {off, 3'b000}) : '0;
                            off_q               <= off;
                            size_q              <= dec_size;
                            sign_q              <= dec_sign;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus.mem_resp || timeout) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus.rsp_err   <= bus.mem_resp ? 2'b00 : 2'b10;
                        bus.rsp_data  <= (bus.mem_resp && bus.mem_read) ? rd_ext : '0;
                        bus.rmask     <= (bus.mem_resp && bus.mem_read) ? bus.mem_byte_enable : '0;
                        bus.wmask     <= (bus.mem_resp && bus.mem_write) ? bus.mem_byte_enable : '0;
                    end else if (wait_cnt != CW'(WAIT_MAX)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    bus.rsp_data <= '0;
                    bus.rsp_err  <= 2'b00;
                    bus.rmask    <= '0;
                    bus.wmask    <= '0;
                end
            endcase
        end
    end
endmodule
